// File: rtl/riscv_pkg.sv
// Shared ALU op codes, sequencer state encoding and width default for the
// multi-cycle MUL/DIV/MOD unit.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [3:0] ALUOP_MUL = 4'b0010;
  localparam logic [3:0] ALUOP_DIV = 4'b0011;
  localparam logic [3:0] ALUOP_MOD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

  function automatic logic is_muldiv_op(input logic [3:0] op);
    return (op == ALUOP_MUL) || (op == ALUOP_DIV) || (op == ALUOP_MOD);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned shift-add multiplier or the
// restoring divider; acc is the product high half / partial remainder.
module muldiv_step
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, operand};
    shifted  = {acc, q[XLEN-1]};
    fits     = shifted >= {1'b0, operand};
    // When the divisor fits, the true difference is below 2^XLEN, so the
    // truncated subtraction is exact.
    diff     = shifted[XLEN-1:0] - operand;
    acc_next = acc;
    q_next   = q;
    if (is_div) begin
      if (fits) begin
        acc_next = diff;
        q_next   = {q[XLEN-2:0], 1'b1};
      end else begin
        acc_next = shifted[XLEN-1:0];
        q_next   = {q[XLEN-2:0], 1'b0};
      end
    end else if (q[0]) begin
      acc_next = sum[XLEN:1];
      q_next   = {sum[0], q[XLEN-1:1]};
    end else begin
      acc_next = {1'b0, acc[XLEN-1:1]};
      q_next   = {acc[0], q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV/MOD sequencer that stalls the EX stage while iterating.
// Optional MULDIV_EARLY_OUT_EN resolves trivial operands at the accept edge.
module muldiv_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      alu_op,
  input  logic            flush,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned     CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t state, state_next;

  logic [CW-1:0]   counter;
  logic [3:0]      op_r;
  logic [XLEN-1:0] acc, q, operand_r, a_r;
  logic            neg_quot, neg_rem, b_zero_r, ovf_r;

  logic            valid_op, accept, early, b_zero, ovf;
  logic [XLEN-1:0] abs_a, abs_b, acc_next, q_next, fix_result;

  assign valid_op = is_muldiv_op(alu_op);
  assign accept   = (state == IDLE) && start && valid_op && !flush;
  assign abs_a    = operand_a[XLEN-1] ? -operand_a : operand_a;
  assign abs_b    = operand_b[XLEN-1] ? -operand_b : operand_b;
  assign b_zero   = (operand_b == '0);
  assign ovf      = (operand_a == MOST_NEG) && (operand_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] early_result;

  always_comb begin
    early        = 1'b0;
    early_result = '0;
    if (alu_op == ALUOP_MUL) begin
      early = (operand_a == '0) || b_zero;
    end else begin
      early = b_zero || ovf;
      if (alu_op == ALUOP_DIV) early_result = b_zero ? '1 : MOST_NEG;
      else                     early_result = b_zero ? operand_a : '0;
    end
  end
`else
  assign early = 1'b0;
`endif

  assign stall = !rst && (((state == IDLE) && start && valid_op && !flush) ||
                          (state == CALC) || (state == FIX));
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = early ? DONE : CALC;
      CALC: begin
        if (flush)                 state_next = IDLE;
        else if (counter == LAST)  state_next = FIX;
      end
      FIX:     state_next = flush ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (op_r != ALUOP_MUL),
    .acc      (acc),
    .q        (q),
    .operand  (operand_r),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  always_comb begin
    fix_result = neg_quot ? -q : q;
    if (op_r == ALUOP_DIV) begin
      if (b_zero_r)   fix_result = '1;
      else if (ovf_r) fix_result = MOST_NEG;
    end else if (op_r == ALUOP_MOD) begin
      if (b_zero_r)   fix_result = a_r;
      else if (ovf_r) fix_result = '0;
      else            fix_result = neg_rem ? -acc : acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter   <= '0;
      op_r      <= '0;
      acc       <= '0;
      q         <= '0;
      operand_r <= '0;
      a_r       <= '0;
      neg_quot  <= 1'b0;
      neg_rem   <= 1'b0;
      b_zero_r  <= 1'b0;
      ovf_r     <= 1'b0;
      result    <= '0;
    end else begin
      if (accept) begin
        op_r      <= alu_op;
        counter   <= '0;
        acc       <= '0;
        q         <= (alu_op == ALUOP_MUL) ? abs_b : abs_a;
        operand_r <= (alu_op == ALUOP_MUL) ? abs_a : abs_b;
        a_r       <= operand_a;
        neg_quot  <= operand_a[XLEN-1] ^ operand_b[XLEN-1];
        neg_rem   <= operand_a[XLEN-1];
        b_zero_r  <= b_zero;
        ovf_r     <= ovf;
`ifdef MULDIV_EARLY_OUT_EN
        if (early) result <= early_result;
`endif
      end
      // XLEN is a power of two, so the counter wraps to 0 after the last step.
      if (state == CALC) begin
        acc     <= acc_next;
        q       <= q_next;
        counter <= counter + 1'b1;
      end
      if ((state == FIX) && !flush) result <= fix_result;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (XLEN=32); latency of
// special-case ops follows MULDIV_EARLY_OUT_EN.
module tb_muldiv_sequencer;
  import riscv_pkg::*;

  localparam int unsigned W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 34;
`endif

  logic         clk = 1'b0;
  logic         rst, start, flush, stall, done;
  logic [3:0]   alu_op;
  logic [W-1:0] operand_a, operand_b, result;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu_op    (alu_op),
    .flush     (flush),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .stall     (stall),
    .done      (done),
    .result    (result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Current cycle is the accept cycle (0) with inputs already driven.
  task automatic wait_done(input int exp_cycle, input logic [W-1:0] exp, input string name);
    int cyc = 0;
    bit seen = 1'b0;
    bit stall_ok = 1'b1;
    while (!seen && cyc <= 100) begin
      #2;
      if (done === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (cyc !== exp_cycle) begin
          errors++;
          $display("FAIL %s_latency: done at cycle %0d, required %0d", name, cyc, exp_cycle);
        end
        checks++;
        if (result !== exp) begin
          errors++;
          $display("FAIL %s_result: got %h, required %h", name, result, exp);
        end
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL %s_stall_done: stall %b in done cycle, required 0", name, stall);
        end
      end else if (stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
      tick();
      cyc++;
      if (cyc == 1) begin
        operand_a = 32'hA5A5_0F0F;
        operand_b = 32'h0000_0000;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no done within 100 cycles, required at %0d", name, exp_cycle);
    end
    checks++;
    if (!stall_ok) begin
      errors++;
      $display("FAIL %s_stall_busy: stall dropped before done, required 1", name);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input logic [W-1:0] exp, input string name);
    start = 1'b1; alu_op = op; operand_a = a; operand_b = b;
    wait_done(lat, exp, name);
    start = 1'b0; alu_op = 4'b0000; operand_a = '0; operand_b = '0;
    #2;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: done %b after completion, required 0", name, done);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s_hold: result %h after completion, required %h", name, result, exp);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; alu_op = ALUOP_MUL; operand_a = 32'd7; operand_b = 32'd3;
    #2;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_forced: got %b, required 0", stall); end
    tick(); tick();
    rst = 1'b0; start = 1'b0; alu_op = 4'b0000;
    #2;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, required 0", stall); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++;
    if (result !== '0) begin errors++; $display("FAIL reset_result: got %h, required 0", result); end
    tick();
  endtask

  task automatic test_mul();
    run_op(ALUOP_MUL, 32'd7,         32'hFFFF_FFFD, 34,          32'hFFFF_FFEB, "mul_7_m3");
    run_op(ALUOP_MUL, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 34,          32'h0000_001E, "mul_m5_m6");
    run_op(ALUOP_MUL, 32'h1234_5678, 32'h0000_0010, 34,          32'h2345_6780, "mul_shift");
    run_op(ALUOP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 34,          32'h8000_0000, "mul_minneg");
    run_op(ALUOP_MUL, 32'd0,         32'h0000_1234, SPECIAL_LAT, 32'h0000_0000, "mul_zero");
  endtask

  task automatic test_div();
    run_op(ALUOP_DIV, 32'd100,       32'd7,         34, 32'h0000_000E, "div_100_7");
    run_op(ALUOP_MOD, 32'd100,       32'd7,         34, 32'h0000_0002, "mod_100_7");
    run_op(ALUOP_DIV, 32'hFFFF_FFEC, 32'd3,         34, 32'hFFFF_FFFA, "div_m20_3");
    run_op(ALUOP_MOD, 32'hFFFF_FFEC, 32'd3,         34, 32'hFFFF_FFFE, "mod_m20_3");
    run_op(ALUOP_MOD, 32'd20,        32'hFFFF_FFFD, 34, 32'h0000_0002, "mod_20_m3");
    run_op(ALUOP_DIV, 32'd7,         32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, "div_7_m2");
    run_op(ALUOP_DIV, 32'h8000_0000, 32'd2,         34, 32'hC000_0000, "div_minneg_2");
  endtask

  task automatic test_special();
    run_op(ALUOP_DIV, 32'd5,         32'd0,         SPECIAL_LAT, 32'hFFFF_FFFF, "div_by0");
    run_op(ALUOP_MOD, 32'd5,         32'd0,         SPECIAL_LAT, 32'h0000_0005, "mod_by0");
    run_op(ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, SPECIAL_LAT, 32'h8000_0000, "div_ovf");
    run_op(ALUOP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, SPECIAL_LAT, 32'h0000_0000, "mod_ovf");
  endtask

  task automatic test_flush();
    bit busy_ok = 1'b1;
    run_op(ALUOP_MOD, 32'd100, 32'd7, 34, 32'h0000_0002, "flush_prior");
    start = 1'b1; alu_op = ALUOP_DIV; operand_a = 32'd1000; operand_b = 32'd3;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) flush = 1'b1;
      #2;
      if (stall !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      tick();
    end
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL flush_busy: stall/done wrong before flush edge, required 1/0"); end
    flush = 1'b0; start = 1'b0; alu_op = 4'b0000;
    #2;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b, required 0", stall); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b, required 0", done); end
    checks++;
    if (result !== 32'h0000_0002) begin errors++; $display("FAIL flush_result_hold: got %h, required 00000002", result); end
    tick();
    run_op(ALUOP_MUL, 32'd3, 32'd4, 34, 32'h0000_000C, "flush_next_mul");
  endtask

  task automatic test_flush_idle();
    bit quiet = 1'b1;
    start = 1'b1; alu_op = ALUOP_MUL; operand_a = 32'd9; operand_b = 32'd9; flush = 1'b1;
    #2;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_start_stall: got %b, required 0", stall); end
    tick();
    start = 1'b0; flush = 1'b0; alu_op = 4'b0000;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (stall !== 1'b0 || done !== 1'b0) quiet = 1'b0;
      tick();
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL flush_start_accept: op accepted under flush, required no stall/done"); end
  endtask

  task automatic test_flush_done();
    start = 1'b1; alu_op = ALUOP_MUL; operand_a = 32'd2; operand_b = 32'd3;
    for (int c = 0; c < 34; c++) tick();
    flush = 1'b1;
    #2;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL flush_in_done_pulse: done %b, required 1", done); end
    checks++;
    if (result !== 32'd6) begin errors++; $display("FAIL flush_in_done_result: got %h, required 00000006", result); end
    tick();
    flush = 1'b0; start = 1'b0; alu_op = 4'b0000;
    #2;
    checks++;
    if (done !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_done_idle: done %b stall %b, required 0 0", done, stall);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit busy_ok = 1'b1;
    start = 1'b1; alu_op = ALUOP_MUL; operand_a = 32'd6; operand_b = 32'd7;
    for (int c = 0; c < 34; c++) begin
      #2;
      if (stall !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      tick();
    end
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL b2b_mul_busy: stall/done wrong during MUL, required 1/0"); end
    alu_op = ALUOP_DIV; operand_a = 32'd100; operand_b = 32'd7;
    #2;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_mul_done: got %b, required 1", done); end
    checks++;
    if (result !== 32'd42) begin errors++; $display("FAIL b2b_mul_result: got %h, required 0000002a", result); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL b2b_done_stall: got %b, required 0", stall); end
    tick();
    wait_done(34, 32'h0000_000E, "b2b_div");
    start = 1'b0; alu_op = 4'b0000;
    tick();
  endtask

  task automatic test_invalid();
    bit quiet = 1'b1;
    start = 1'b1; alu_op = 4'b0000; operand_a = 32'd1; operand_b = 32'd2;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (stall !== 1'b0 || done !== 1'b0) quiet = 1'b0;
      tick();
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL invalid_op: stall/done seen for ADD, required none"); end
    start = 1'b0;
  endtask

  task automatic test_rst_mid();
    bit quiet = 1'b1;
    start = 1'b1; alu_op = ALUOP_MUL; operand_a = 32'd7; operand_b = 32'd9;
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    #2;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b, required 0", stall); end
    tick();
    rst = 1'b0; start = 1'b0; alu_op = 4'b0000;
    #2;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: stall %b done %b result %h, required 0 0 0", stall, done, result);
    end
    tick();
    for (int c = 0; c < 40; c++) begin
      #2;
      if (done !== 1'b0) quiet = 1'b0;
      tick();
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL rst_mid_no_done: done pulsed after reset, required none"); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; alu_op = 4'b0000;
    operand_a = '0; operand_b = '0;
    tick();
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_flush_idle();
    test_flush_done();
    test_back_to_back();
    test_invalid();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle execution unit and sequencer for the EX-stage ALU ops MUL, DIV and MOD, which are too slow for the single-cycle ALU.
- Accepts one op from the EX stage, stalls the pipeline while it iterates shift-add / restoring-divide steps, then presents the result for one cycle.
- Sits beside the ALU; the EX-stage result mux selects `result` when `done` is high.

Parameters:
- XLEN, 32, operand/result width (power of two, ≥8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  EX stage holds a valid instruction (held until `done`).
- alu_op  in  4  ALUOp from the control unit; only MUL/DIV/MOD codes accepted.
- flush  in  1  pipeline flush (branch/jump); aborts operation.
- operand_a  in  XLEN  rs1 value (dividend / multiplicand), signed.
- operand_b  in  XLEN  rs2 value (divisor / multiplier), signed.
- stall  out  1  freeze IF/ID/EX; combinational.
- done  out  1  one-cycle pulse; `result` valid.
- result  out  XLEN  registered result; holds until next completion.

Behaviour:
- Reset: state=IDLE, `done`=0, `result`=0, counter=0, `stall`=0 (rst forces stall low).
- Accept: in IDLE, `start` & valid op & !`flush` captures op and operands at the edge. Operand changes after accept are ignored. An invalid `alu_op` is ignored: no stall, no accept.
- States:
  - IDLE: accept goes to CALC.
  - CALC: XLEN iterations on absolute values; counter counts 0..XLEN-1, then goes to FIX.
  - FIX: applies sign correction, loads `result`, then goes to DONE.
  - DONE: `done`=1 for one cycle, then goes to IDLE unconditionally. `start` is ignored in DONE, so the same instruction is never re-accepted.
- Latency: accept cycle = 0; CALC cycles 1..XLEN; FIX XLEN+1; `done` at cycle XLEN+2 (34 for XLEN=32).
- Stall:
  - stall = (IDLE & `start` & valid op) | CALC | FIX.
  - High cycles 0..XLEN+1; low in DONE so the pipeline advances that cycle.
- Arithmetic:
  - MUL: low XLEN bits of signed product.
  - DIV: signed quotient, truncated toward zero.
  - MOD: signed remainder; sign follows the dividend.
  - Magnitude of the most-negative value is handled as unsigned XLEN bits.
- Special cases (RISC-V semantics):
  - Divisor 0: DIV=all ones, MOD=operand_a.
  - Overflow (-2^(XLEN-1) / -1): DIV=-2^(XLEN-1), MOD=0.
  - Without the optional feature, these still take full latency.
- Flush:
  - Any non-IDLE state goes to IDLE next edge. No `done`; `result` unchanged.
  - `stall` is deasserted in the flush cycle only if state returns to IDLE; it is combinationally low when `flush` & IDLE.
  - Flush in DONE: `done` still pulses (instruction completing), then IDLE.
- rst mid-operation: immediate return to reset values at next edge; no `done`.
- Simultaneous `flush` & `start` in IDLE: flush wins, no accept.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined:
  - Divisor 0, overflow, or operand_a==0 / operand_b==0 for MUL are detected at accept.
  - These skip CALC/FIX: `result` is loaded at the accept edge and `done` pulses at cycle 1.
  - `stall` is high in cycle 0 only.
- Undefined: all ops take XLEN+2 cycles. Results are identical either way.

Decomposition:
- Shared package (`riscv_pkg`):
  - ALUOP_MUL=4'b0010, ALUOP_DIV=4'b0011, ALUOP_MOD=4'b1111.
  - State encoding: IDLE, CALC, FIX, DONE.
  - XLEN default.
- Sub-module `muldiv_step`: combinational single iteration.
  - Multiply: conditional add + shift.
  - Divide: trial subtract + shift.
  - Instantiated once inside the sequencer's CALC datapath.

Test Plan:
- MUL 7 × -3: stall high cycles 0–33; `done` at cycle 34; `result`=0xFFFFFFEB.
- DIV -20/3 → 0xFFFFFFFA; MOD -20%3 → 0xFFFFFFFE; MOD 20%-3 → 0x00000002.
- DIV 5/0 → 0xFFFFFFFF; MOD 5%0 → 0x00000005; DIV 0x80000000/0xFFFFFFFF → 0x80000000; MOD same operands → 0.
  - Check these with and without MULDIV_EARLY_OUT_EN; with it, `done` at cycle 1.
- Flush at cycle 10 of a DIV: IDLE at cycle 11, no `done`, `result` holds the prior value. A new MUL accepted at cycle 12 completes at cycle 46.
- rst at cycle 5 of a MUL: all outputs 0 next cycle. `start` with `alu_op`=4'b0000 (ADD): `stall` stays 0, no `done` ever.
- Back-to-back: a MUL completing then a DIV presented the cycle after DONE is accepted. The DIV is not accepted in DONE.
